// File: rtl/rf_wb_arbiter_if.sv
// Write request channel from one producer into the write-back arbiter.
// Ports: valid/addr/data from the producer, ready back from the arbiter.
interface rf_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output addr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    output ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: ALU and load paths each feed a 2-entry FIFO,
// drained round-robin into one registered register-bank write port.
// Ports: clk, rst (sync, active-high); alu/mem request channels;
// wr_en/wr_addr/wr_data write port; rs1/rs2 pending lookups.
// Optional RF_WB_ZERO_GUARD_EN: writes to x0 are dropped and never pending.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    alu,
  rf_wb_arbiter_if.slave    mem,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_pending,
  output logic              rs2_pending
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Side 0 is the ALU, side 1 the load path.
  logic [1:0]        in_vld;
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];

  logic [ADDR_W-1:0] q_addr  [2][2];
  logic [DATA_W-1:0] q_data  [2][2];
  logic [CNT_W-1:0]  cnt     [2];
  logic [1:0]        rd_ptr;
  logic [1:0]        wr_ptr;

  logic [1:0]        rdy;
  logic [1:0]        ne;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [ADDR_W-1:0] hd_addr [2];
  logic [DATA_W-1:0] hd_data [2];

  logic              rr_alu;
  logic              sel_a;
  logic              sel_m;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              gnt_wr;

  logic              rs1_hit;
  logic              rs2_hit;

  assign in_vld     = {mem.valid, alu.valid};
  assign in_addr[0] = alu.addr;
  assign in_addr[1] = mem.addr;
  assign in_data[0] = alu.data;
  assign in_data[1] = mem.data;

  for (genvar s = 0; s < 2; s++) begin : g_side
    // Ready comes from the count alone, so a full FIFO
    // cannot take a push in the same cycle it pops.
    assign rdy[s]     = cnt[s] != CNT_W'(FIFO_DEPTH);
    assign ne[s]      = cnt[s] != '0;
    assign hd_addr[s] = q_addr[s][rd_ptr[s]];
    assign hd_data[s] = q_data[s][rd_ptr[s]];
  end

  assign alu.ready = rdy[0];
  assign mem.ready = rdy[1];
  assign push      = in_vld & rdy;

  // The two selects are mutually exclusive by construction.
  assign sel_a = ne[0] & (~ne[1] | rr_alu);
  assign sel_m = ne[1] & (~ne[0] | ~rr_alu);

  always_comb begin
    pop = '0;
    unique case (1'b1)
      sel_a:   pop[0] = 1'b1;
      sel_m:   pop[1] = 1'b1;
      default: pop    = '0;
    endcase
  end

  assign gnt_addr = pop[1] ? hd_addr[1] : hd_addr[0];
  assign gnt_data = pop[1] ? hd_data[1] : hd_data[0];

`ifdef RF_WB_ZERO_GUARD_EN
  // x0 entries still drain; they just never reach the bank.
  assign gnt_wr = (|pop) && (gnt_addr != '0);
`else
  assign gnt_wr = |pop;
`endif

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        q_addr[s][wr_ptr[s]] <= in_addr[s];
        q_data[s][wr_ptr[s]] <= in_data[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt[0]  <= '0;
      cnt[1]  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      rr_alu  <= 1'b1;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= ~wr_ptr[s];
        if (pop[s])  rd_ptr[s] <= ~rd_ptr[s];
        unique case ({push[s], pop[s]})
          2'b10:   cnt[s] <= cnt[s] + CNT_W'(1);
          2'b01:   cnt[s] <= cnt[s] - CNT_W'(1);
          default: cnt[s] <= cnt[s];
        endcase
      end
      if (|pop) rr_alu <= pop[1];
      wr_en <= gnt_wr;
      if (gnt_wr) begin
        wr_addr <= gnt_addr;
        wr_data <= gnt_data;
      end
    end
  end

  // A slot is live when the FIFO is full, or when it is the
  // head of a one-entry FIFO.
  always_comb begin
    logic live;
    rs1_hit = wr_en && (wr_addr == rs1_addr);
    rs2_hit = wr_en && (wr_addr == rs2_addr);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 2; i++) begin
        live = (cnt[s] == CNT_W'(2)) ||
               ((cnt[s] == CNT_W'(1)) && (rd_ptr[s] == 1'(i)));
        if (live && (q_addr[s][i] == rs1_addr)) rs1_hit = 1'b1;
        if (live && (q_addr[s][i] == rs2_addr)) rs2_hit = 1'b1;
      end
    end
  end

`ifdef RF_WB_ZERO_GUARD_EN
  assign rs1_pending = rs1_hit && (rs1_addr != '0);
  assign rs2_pending = rs2_hit && (rs2_addr != '0);
`else
  assign rs1_pending = rs1_hit;
  assign rs2_pending = rs2_hit;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter.
// Checks reset, latency, round-robin order, backpressure, pending flags.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rs1_addr = '0;
  logic [AW-1:0] rs2_addr = '0;
  logic          rs1_pending;
  logic          rs2_pending;

  rf_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a_if ();
  rf_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m_if ();

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu         (a_if),
    .mem         (m_if),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] got_addr [$];
  logic [DW-1:0] got_data [$];

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  endtask

  task automatic idle_inputs();
    a_if.valid = 1'b0;
    a_if.addr  = '0;
    a_if.data  = '0;
    m_if.valid = 1'b0;
    m_if.addr  = '0;
    m_if.data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    got_addr.delete();
    got_data.delete();
  endtask

  task automatic test_reset();
    rs1_addr = 5'd3;
    rs2_addr = 5'd4;
    do_reset();
    checks++;
    if (wr_en !== 1'b0) begin
      errors++; $display("FAIL reset_wr_en got %b want 0", wr_en);
    end
    checks++;
    if (wr_addr !== '0) begin
      errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr);
    end
    checks++;
    if (wr_data !== '0) begin
      errors++; $display("FAIL reset_wr_data got %h want 0", wr_data);
    end
    checks++;
    if (a_if.ready !== 1'b1 || m_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b%b want 11", a_if.ready, m_if.ready);
    end
    checks++;
    if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
      errors++;
      $display("FAIL reset_pending got %b%b want 00", rs1_pending, rs2_pending);
    end
  endtask

  task automatic test_single();
    rs1_addr   = 5'd5;
    a_if.valid = 1'b1;
    a_if.addr  = 5'd5;
    a_if.data  = 32'hDEADBEEF;
    step();
    a_if.valid = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || rs1_pending !== 1'b1) begin
      errors++;
      $display("FAIL single_queued wr_en=%b pend=%b want 0 1",
               wr_en, rs1_pending);
    end
    step();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_write got %b %0d %h want 1 5 deadbeef",
               wr_en, wr_addr, wr_data);
    end
    checks++;
    if (rs1_pending !== 1'b1) begin
      errors++; $display("FAIL single_pend_out got %b want 1", rs1_pending);
    end
    step();
    checks++;
    if (wr_en !== 1'b0 || rs1_pending !== 1'b0 || wr_addr !== 5'd5) begin
      errors++;
      $display("FAIL single_done wr_en=%b pend=%b addr=%0d want 0 0 5",
               wr_en, rs1_pending, wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    int ia = 0;
    int ib = 0;
    int cyc = 0;
    bit acc_a;
    bit acc_m;
    bit saw_a = 1'b0;
    bit saw_m = 1'b0;
    logic [DW-1:0] exp;
    do_reset();
    while (got_data.size() < 16 && cyc < 60) begin
      a_if.valid = (ia < 8);
      a_if.addr  = AW'(1 + ia);
      a_if.data  = DW'(32'hA0 + ia);
      m_if.valid = (ib < 8);
      m_if.addr  = AW'(16 + ib);
      m_if.data  = DW'(32'hB0 + ib);
      acc_a = a_if.valid && a_if.ready;
      acc_m = m_if.valid && m_if.ready;
      if (a_if.valid && !a_if.ready) saw_a = 1'b1;
      if (m_if.valid && !m_if.ready) saw_m = 1'b1;
      step();
      if (acc_a) ia++;
      if (acc_m) ib++;
      cyc++;
    end
    idle_inputs();
    step();
    step();
    checks++;
    if (got_data.size() != 16) begin
      errors++;
      $display("FAIL b2b_count got %0d writes want 16", got_data.size());
    end
    for (int k = 0; k < 16 && k < got_data.size(); k++) begin
      exp = (k % 2 == 0) ? DW'(32'hA0 + k / 2) : DW'(32'hB0 + k / 2);
      checks++;
      if (got_data[k] !== exp) begin
        errors++;
        $display("FAIL b2b_order[%0d] got %h want %h", k, got_data[k], exp);
      end
    end
    checks++;
    if (!saw_a || !saw_m) begin
      errors++;
      $display("FAIL b2b_backpressure saw %b%b want 11", saw_a, saw_m);
    end
    checks++;
    if (a_if.ready !== 1'b1 || m_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_drained_ready got %b%b want 11",
               a_if.ready, m_if.ready);
    end
  endtask

  task automatic test_full_hold();
    logic [AW-1:0] exp_a [6];
    exp_a = '{5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd7};
    do_reset();
    a_if.valid = 1'b1; a_if.addr = 5'd11; a_if.data = 32'h11;
    m_if.valid = 1'b1; m_if.addr = 5'd21; m_if.data = 32'h21;
    step();
    a_if.addr = 5'd12; a_if.data = 32'h12;
    m_if.addr = 5'd22; m_if.data = 32'h22;
    step();
    a_if.addr = 5'd13; a_if.data = 32'h13;
    m_if.valid = 1'b0;
    step();
    checks++;
    if (a_if.ready !== 1'b0) begin
      errors++; $display("FAIL hold_full got ready %b want 0", a_if.ready);
    end
    a_if.addr = 5'd7; a_if.data = 32'h77;
    step();
    checks++;
    if (a_if.ready !== 1'b1) begin
      errors++; $display("FAIL hold_not_taken got ready %b want 1", a_if.ready);
    end
    step();
    checks++;
    if (a_if.ready !== 1'b0) begin
      errors++; $display("FAIL hold_taken got ready %b want 0", a_if.ready);
    end
    a_if.valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (got_addr.size() != 6) begin
      errors++;
      $display("FAIL hold_count got %0d writes want 6", got_addr.size());
    end
    for (int k = 0; k < 6 && k < got_addr.size(); k++) begin
      checks++;
      if (got_addr[k] !== exp_a[k]) begin
        errors++;
        $display("FAIL hold_order[%0d] got %0d want %0d",
                 k, got_addr[k], exp_a[k]);
      end
    end
    if (got_data.size() == 6) begin
      checks++;
      if (got_data[5] !== 32'h77) begin
        errors++; $display("FAIL hold_data got %h want 77", got_data[5]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rs1_addr = 5'd30;
    rs2_addr = 5'd31;
    a_if.valid = 1'b1; a_if.addr = 5'd30; a_if.data = 32'hC0;
    m_if.valid = 1'b1; m_if.addr = 5'd31; m_if.data = 32'hC1;
    for (int k = 0; k < 3; k++) step();
    idle_inputs();
    rst = 1'b1;
    got_addr.delete();
    got_data.delete();
    step();
    rst = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL rstmid_port got %b %0d %h want 0 0 0",
               wr_en, wr_addr, wr_data);
    end
    checks++;
    if (a_if.ready !== 1'b1 || m_if.ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready got %b%b want 11", a_if.ready, m_if.ready);
    end
    checks++;
    if (rs1_pending !== 1'b0 || rs2_pending !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_pending got %b%b want 00",
               rs1_pending, rs2_pending);
    end
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (got_data.size() != 0) begin
      errors++;
      $display("FAIL rstmid_leak got %0d writes want 0", got_data.size());
    end
  endtask

  task automatic test_zero();
    rs1_addr   = 5'd0;
    m_if.valid = 1'b1;
    m_if.addr  = 5'd0;
    m_if.data  = 32'h1234;
    step();
    m_if.valid = 1'b0;
`ifdef RF_WB_ZERO_GUARD_EN
    checks++;
    if (rs1_pending !== 1'b0) begin
      errors++; $display("FAIL zero_pending got %b want 0", rs1_pending);
    end
    step();
    checks++;
    if (wr_en !== 1'b0 || wr_data !== '0) begin
      errors++;
      $display("FAIL zero_write got %b %h want 0 0", wr_en, wr_data);
    end
`else
    checks++;
    if (rs1_pending !== 1'b1) begin
      errors++; $display("FAIL zero_pending got %b want 1", rs1_pending);
    end
    step();
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd0 || wr_data !== 32'h1234) begin
      errors++;
      $display("FAIL zero_write got %b %0d %h want 1 0 1234",
               wr_en, wr_addr, wr_data);
    end
`endif
    step();
  endtask

  task automatic test_same_reg();
    rs1_addr = 5'd3;
    rs2_addr = 5'd9;
    a_if.valid = 1'b1; a_if.addr = 5'd9; a_if.data = 32'h91;
    m_if.valid = 1'b1; m_if.addr = 5'd9; m_if.data = 32'h92;
    step();
    idle_inputs();
    checks++;
    if (rs2_pending !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL same_queued pend=%b wr_en=%b want 1 0",
               rs2_pending, wr_en);
    end
    step();
    checks++;
    if (rs2_pending !== 1'b1 || wr_en !== 1'b1 || wr_data !== 32'h91) begin
      errors++;
      $display("FAIL same_first pend=%b wr_en=%b data=%h want 1 1 91",
               rs2_pending, wr_en, wr_data);
    end
    step();
    checks++;
    if (rs2_pending !== 1'b1 || wr_en !== 1'b1 || wr_data !== 32'h92) begin
      errors++;
      $display("FAIL same_second pend=%b wr_en=%b data=%h want 1 1 92",
               rs2_pending, wr_en, wr_data);
    end
    checks++;
    if (rs1_pending !== 1'b0) begin
      errors++; $display("FAIL same_other got %b want 0", rs1_pending);
    end
    step();
    checks++;
    if (rs2_pending !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL same_done pend=%b wr_en=%b want 0 0",
               rs2_pending, wr_en);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_full_hold();
    test_reset_mid();
    test_zero();
    test_same_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
